free_list: RTL

- Circular FIFO of free physical register indices. It answers the dispatch-side free-list request (preg_request / preg_addr / fl_empty).
- It is refilled by ROB commit, which returns the stale physical register of each retiring rd-writing instruction.
- On pipeline flush it recovers in one cycle by reclaiming every speculatively allocated register.
- Sits between dispatch (consumer) and the ROB commit stage (producer).

---
 rtl/free_list.sv | 114 +++++++++++
 1 files changed

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register indices.
// Dispatch pops the head (combinational read); ROB commit pushes stale pregs
// at the tail; flush reclaims every speculatively allocated preg in one cycle.
// Optional feature macro: FREE_LIST_BYPASS_EN (empty-list hand-off of a
// same-cycle returned register straight to dispatch).
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  localparam int PHYS_WIDTH = $clog2(NUM_PREGS),
  localparam int CAP = NUM_PREGS - NUM_AREGS,
  localparam int PTR_W = $clog2(CAP),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  preg_request,
  output logic [PHYS_WIDTH-1:0] preg_addr,
  output logic                  fl_empty,
  input  logic                  free_valid,
  input  logic [PHYS_WIDTH-1:0] free_preg,
  input  logic                  flush,
  output logic [CNT_W-1:0]      fl_count,
  output logic                  fl_overflow
);

  logic [PHYS_WIDTH-1:0] mem_r [CAP];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;
  logic                  overflow_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  deq_s;
  logic                  drop_s;
  logic                  handoff_s;
  logic                  enq_s;
  logic [PTR_W-1:0]      tail_next_s;
`ifdef FREE_LIST_BYPASS_EN
  logic                  bypass_s;
`endif

  // Occupancy flags and the dequeue/enqueue/drop decisions for this cycle.
  always_comb begin
    empty_s = (count_r == CNT_W'(0));
    full_s  = (count_r == CNT_W'(CAP));
    // A flush discards the request: the head is about to be rewound anyway.
    deq_s   = preg_request && !empty_s && !flush;
    // When full, a return only fits if the head slot is vacated this cycle.
    drop_s  = free_valid && full_s && !deq_s;
`ifdef FREE_LIST_BYPASS_EN
    bypass_s  = empty_s && free_valid && !flush;
    handoff_s = bypass_s && preg_request;
`else
    handoff_s = 1'b0;
`endif
    // A handed-off register never touches the storage.
    enq_s       = free_valid && !drop_s && !handoff_s;
    tail_next_s = tail_r + PTR_W'(enq_s);
  end

  // Head-entry read for dispatch; zero when nothing is available.
  always_comb begin
    fl_empty  = empty_s;
    preg_addr = {PHYS_WIDTH{1'b0}};
    if (!empty_s) begin
      preg_addr = mem_r[head_r];
    end else begin
`ifdef FREE_LIST_BYPASS_EN
      if (bypass_s) begin
        fl_empty  = 1'b0;
        preg_addr = free_preg;
      end else begin
        preg_addr = {PHYS_WIDTH{1'b0}};
      end
`else
      preg_addr = {PHYS_WIDTH{1'b0}};
`endif
    end
  end

  // Storage, pointers, occupancy and sticky overflow; flush rewinds the head
  // onto the post-enqueue tail so every in-flight allocation becomes free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CAP; i++) begin
        mem_r[i] <= PHYS_WIDTH'(NUM_AREGS + i);
      end
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= CNT_W'(CAP);
      overflow_r <= 1'b0;
    end else begin
      if (enq_s) begin
        mem_r[tail_r] <= free_preg;
      end else begin
        mem_r[tail_r] <= mem_r[tail_r];
      end
      tail_r <= tail_next_s;
      if (flush) begin
        head_r  <= tail_next_s;
        count_r <= CNT_W'(CAP);
      end else begin
        head_r  <= head_r + PTR_W'(deq_s);
        count_r <= count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
      end
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign fl_count    = count_r;
  assign fl_overflow = overflow_r;

endmodule
